// File: rtl/rcv_bit_timer.sv
// rcv_bit_timer: receive bit timer that tracks bit phase from d_edge, strobes one sample per bit and frames words.
// Build option RCV_BIT_STUFF_EN adds USB bit-stuff removal (stuff_skip) and stuff error flagging (stuff_err).
module rcv_bit_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_PHASE  = 3,
    parameter int BITS_PER_WORD = 8,
    localparam int CW = $clog2(BITS_PER_WORD + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          d_edge,
    input  logic          rcving,
    input  logic          bit_in,
    output logic          shift_enable,
    output logic          byte_received,
    output logic [CW-1:0] bit_count,
    output logic          stuff_skip,
    output logic          stuff_err
);
    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PHASE);
    localparam logic [CW-1:0] WORD_LAST = CW'(BITS_PER_WORD - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("rcv_bit_timer: CLKS_PER_BIT must be >= 4");
    end
    if (SAMPLE_PHASE < 0 || SAMPLE_PHASE >= CLKS_PER_BIT) begin : g_bad_phase
        $error("rcv_bit_timer: SAMPLE_PHASE must be in 0..CLKS_PER_BIT-1");
    end
    if (BITS_PER_WORD < 2) begin : g_bad_word
        $error("rcv_bit_timer: BITS_PER_WORD must be >= 2");
    end

    logic [PW-1:0] ph;
    logic          sample_pt;
    logic          stuff_now;

    // Qualified by n_rst so the strobe is dead during reset even when SAMPLE_PHASE is 0.
    assign sample_pt    = n_rst && rcving && (ph == PH_SAMPLE);
    assign shift_enable = sample_pt && !stuff_now;
    assign stuff_skip   = stuff_now;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ph <= '0;
        end else if (!rcving || d_edge) begin
            ph <= '0;
        end else if (ph == PH_LAST) begin
            ph <= '0;
        end else begin
            ph <= ph + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_count     <= '0;
            byte_received <= 1'b0;
        end else begin
            byte_received <= 1'b0;
            if (!rcving) begin
                bit_count <= '0;
            end else if (shift_enable) begin
                if (bit_count == WORD_LAST) begin
                    bit_count     <= '0;
                    byte_received <= 1'b1;
                end else begin
                    bit_count <= bit_count + 1'b1;
                end
            end
        end
    end

`ifdef RCV_BIT_STUFF_EN
    logic [2:0] ones;

    // Run of sampled ones spans word boundaries; only leaving reception clears it.
    assign stuff_now = sample_pt && (ones == 3'd6);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones      <= 3'd0;
            stuff_err <= 1'b0;
        end else begin
            stuff_err <= 1'b0;
            if (!rcving) begin
                ones <= 3'd0;
            end else if (stuff_now) begin
                ones      <= 3'd0;
                stuff_err <= bit_in;
            end else if (sample_pt) begin
                ones <= bit_in ? ones + 3'd1 : 3'd0;
            end
        end
    end
`else
    logic unused_bit_in;

    assign unused_bit_in = bit_in;
    assign stuff_now     = 1'b0;
    assign stuff_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rcv_bit_timer.sv
// Self-checking bench for rcv_bit_timer: directed timing scenarios plus randomized traffic against a phase-arithmetic model.
`timescale 1ns/1ps
module tb_rcv_bit_timer;
    localparam int CPB = 8;
    localparam int SP  = 3;
    localparam int BPW = 8;
    localparam int CW  = $clog2(BPW + 1);
`ifdef RCV_BIT_STUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic d_edge = 1'b0;
    logic rcving = 1'b0;
    logic bit_in = 1'b0;
    logic shift_enable, byte_received, stuff_skip, stuff_err;
    logic [CW-1:0] bit_count;

    int checks = 0;
    int errors = 0;

    // Reference model: bit phase is (cycle - anchor) mod CPB, anchor being the first cycle after a clear.
    int cyc = 0;
    int anchor = 0;
    int m_count = 0;
    int m_ones = 0;
    bit m_br = 1'b0;
    bit m_err = 1'b0;

    logic obs_se, obs_br, obs_skip, obs_err;
    logic [CW-1:0] obs_bc;
    bit exp_se, exp_br, exp_skip, exp_err;
    int exp_bc;

    rcv_bit_timer #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_PHASE (SP),
        .BITS_PER_WORD(BPW)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .rcving       (rcving),
        .bit_in       (bit_in),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .bit_count    (bit_count),
        .stuff_skip   (stuff_skip),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic model_reset();
        anchor  = cyc;
        m_count = 0;
        m_ones  = 0;
        m_br    = 1'b0;
        m_err   = 1'b0;
    endtask

    // Drive one cycle from posedge+1, snapshot outputs at negedge, advance the model, end at next posedge+1.
    task automatic step(input bit e, input bit r, input bit b);
        bit samp, stuff;
        d_edge = e;
        rcving = r;
        bit_in = b;
        @(negedge clk);
        obs_se   = shift_enable;
        obs_br   = byte_received;
        obs_bc   = bit_count;
        obs_skip = stuff_skip;
        obs_err  = stuff_err;
        samp     = r && (((cyc - anchor) % CPB) == SP);
        stuff    = STUFF && samp && (m_ones == 6);
        exp_se   = samp && !stuff;
        exp_skip = stuff;
        exp_br   = m_br;
        exp_err  = m_err;
        exp_bc   = m_count;
        m_br  = 1'b0;
        m_err = 1'b0;
        if (!r) begin
            m_count = 0;
            m_ones  = 0;
        end else begin
            if (exp_se) begin
                if (m_count == BPW - 1) begin
                    m_count = 0;
                    m_br    = 1'b1;
                end else begin
                    m_count++;
                end
            end
            if (stuff) begin
                m_ones = 0;
                m_err  = b;
            end else if (samp) begin
                m_ones = b ? m_ones + 1 : 0;
            end
        end
        if (!r || e) anchor = cyc + 1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rcving = 1'b1;
        @(negedge clk);
        checks++;
        if ({shift_enable, byte_received, stuff_skip, stuff_err} !== 4'b0000 || bit_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs got se=%0b br=%0b sk=%0b er=%0b bc=%0d exp all 0",
                     shift_enable, byte_received, stuff_skip, stuff_err, bit_count);
        end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_reset();
        for (int t = 0; t < 36; t++) step(1'b0, 1'b1, 1'b0);
        checks++;
        if (bit_count !== CW'(5)) begin
            errors++;
            $display("FAIL reset_pre_count got=%0d exp=5", bit_count);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({shift_enable, byte_received, stuff_skip, stuff_err} !== 4'b0000 || bit_count !== '0) begin
            errors++;
            $display("FAIL reset_midpacket got se=%0b br=%0b sk=%0b er=%0b bc=%0d exp all 0",
                     shift_enable, byte_received, stuff_skip, stuff_err, bit_count);
        end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_bc !== '0 || obs_se !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got bc=%0d se=%0b exp bc=0 se=0", obs_bc, obs_se);
        end
    endtask

    task automatic test_free_run();
        bit want;
        repeat (2) step(1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 80; t++) begin
            step(t == 10, t >= 8, 1'b0);
            want = (t >= 14) && (((t - 14) % 8) == 0);
            checks++;
            if (obs_se !== want) begin
                errors++;
                $display("FAIL free_run_shift t=%0d got=%0b exp=%0b", t, obs_se, want);
            end
            checks++;
            if (obs_br !== (t == 71)) begin
                errors++;
                $display("FAIL free_run_byte t=%0d got=%0b exp=%0b", t, obs_br, (t == 71));
            end
        end
    endtask

    task automatic test_resync();
        bit want;
        repeat (2) step(1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 32; t++) begin
            step((t == 10) || (t == 20), t >= 8, 1'b0);
            want = (t == 14) || (t == 24);
            checks++;
            if (obs_se !== want) begin
                errors++;
                $display("FAIL resync_shift t=%0d got=%0b exp=%0b", t, obs_se, want);
            end
        end
    endtask

    task automatic test_abort();
        int pulses;
        repeat (2) step(1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_se !== 1'b0) begin
            errors++;
            $display("FAIL abort_on_sample got se=%0b exp=0", obs_se);
        end
        step(1'b0, 1'b0, 1'b0);
        pulses = 0;
        for (int t = 0; t < 40; t++) begin
            step(1'b0, 1'b1, 1'b0);
            if (obs_br) pulses++;
        end
        checks++;
        if (obs_bc !== CW'(5)) begin
            errors++;
            $display("FAIL abort_partial_count got=%0d exp=5", obs_bc);
        end
        step(1'b0, 1'b0, 1'b0);
        if (obs_br) pulses++;
        step(1'b0, 1'b0, 1'b0);
        if (obs_br) pulses++;
        checks++;
        if (obs_bc !== '0 || pulses != 0) begin
            errors++;
            $display("FAIL abort_discard got bc=%0d pulses=%0d exp bc=0 pulses=0", obs_bc, pulses);
        end
        pulses = 0;
        for (int t = 0; t < 80; t++) begin
            step(1'b0, 1'b1, 1'b0);
            if (obs_br) pulses++;
        end
        checks++;
        if (pulses != 1 || obs_bc !== CW'(2)) begin
            errors++;
            $display("FAIL abort_next_packet got pulses=%0d bc=%0d exp pulses=1 bc=2", pulses, obs_bc);
        end
    endtask

    task automatic test_stuffing();
        int shifts, errs, skips;
        bit b;
`ifdef RCV_BIT_STUFF_EN
        bit pat [8];
        pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        repeat (2) step(1'b0, 1'b0, 1'b0);
        for (int t = 0; t <= 60; t++) begin
            if (t >= 3 && ((t - 3) % 8) == 0 && ((t - 3) / 8) < 8) b = pat[(t - 3) / 8];
            else b = 1'($urandom_range(0, 1));
            step(1'b0, 1'b1, b);
            if (t == 51) begin
                checks++;
                if (obs_skip !== 1'b1 || obs_se !== 1'b0) begin
                    errors++;
                    $display("FAIL stuff_skip_7th got sk=%0b se=%0b exp sk=1 se=0", obs_skip, obs_se);
                end
            end
            if (t == 52) begin
                checks++;
                if (obs_err !== 1'b0) begin
                    errors++;
                    $display("FAIL stuff_zero_noerr got=%0b exp=0", obs_err);
                end
            end
        end
        checks++;
        if (obs_bc !== CW'(7)) begin
            errors++;
            $display("FAIL stuff_count_8th got=%0d exp=7", obs_bc);
        end
`endif
        repeat (2) step(1'b0, 1'b0, 1'b0);
        shifts = 0;
        errs   = 0;
        skips  = 0;
        for (int t = 0; t < 56; t++) begin
            step(1'b0, 1'b1, 1'b1);
            if (obs_se) shifts++;
            if (obs_err) errs++;
            if (obs_skip) skips++;
`ifdef RCV_BIT_STUFF_EN
            if (t == 52) begin
                checks++;
                if (obs_err !== 1'b1) begin
                    errors++;
                    $display("FAIL stuff_err_pulse got=%0b exp=1", obs_err);
                end
            end
`endif
        end
        checks++;
        if (shifts != (STUFF ? 6 : 7) || errs != (STUFF ? 1 : 0) || skips != (STUFF ? 1 : 0)) begin
            errors++;
            $display("FAIL seven_ones got shifts=%0d errs=%0d skips=%0d exp %0d/%0d/%0d",
                     shifts, errs, skips, STUFF ? 6 : 7, STUFF ? 1 : 0, STUFF ? 1 : 0);
        end
    endtask

    task automatic test_random();
        bit e, r, b;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) < 97);
            e = ($urandom_range(0, 9) == 0);
            b = ($urandom_range(0, 3) != 0);
            step(e, r, b);
            checks++;
            if (obs_se !== exp_se) begin
                errors++;
                $display("FAIL random_shift cyc=%0d got=%0b exp=%0b", cyc, obs_se, exp_se);
            end
            checks++;
            if (obs_br !== exp_br) begin
                errors++;
                $display("FAIL random_byte cyc=%0d got=%0b exp=%0b", cyc, obs_br, exp_br);
            end
            checks++;
            if (obs_bc !== CW'(exp_bc)) begin
                errors++;
                $display("FAIL random_count cyc=%0d got=%0d exp=%0d", cyc, obs_bc, exp_bc);
            end
            checks++;
            if (obs_skip !== exp_skip) begin
                errors++;
                $display("FAIL random_skip cyc=%0d got=%0b exp=%0b", cyc, obs_skip, exp_skip);
            end
            checks++;
            if (obs_err !== exp_err) begin
                errors++;
                $display("FAIL random_err cyc=%0d got=%0b exp=%0b", cyc, obs_err, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_resync();
        test_abort();
        test_stuffing();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
